// File: rtl/tpu_ctrl_pkg.sv
// Shared types and sizing helpers for the TPU tile control path.
package tpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP_W,
    ST_RELOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Skew in, array traversal, deskew out, plus two register stages.
  function automatic int default_pipe_lat(input int matrix_size);
    return 2 * matrix_size + 2;
  endfunction

  function automatic int row_cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

  localparam int DEFAULT_MATRIX_SIZE = 32;
  localparam int DEFAULT_PIPE_LAT    = default_pipe_lat(DEFAULT_MATRIX_SIZE);

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit valid shift register used to align strobes with pipeline results.
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = din;
    if (clear) sr_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Start/busy/done sequencer for one matrix-multiply tile: weight pop and reload,
// UB streaming, and result write-back aligned through a valid delay line.
module tpu_tile_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int MATRIX_SIZE = 32,
  parameter int PIPE_LAT    = default_pipe_lat(MATRIX_SIZE)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE:0]   num_rows,
  input  logic [ADDRESSSIZE-1:0] ub_base,
  input  logic [ADDRESSSIZE-1:0] res_base,
  input  logic                   acc_mode,
  output logic                   busy,
  output logic                   done,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic                   ub_read_en,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   res_accumulate
);

  localparam int ROW_W = row_cnt_width(ADDRESSSIZE);

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fifo_q, fifo_d;
  logic                   we_rl_q, we_rl_d;
  logic                   ub_en_q, ub_en_d;
  logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
  logic [ADDRESSSIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ROW_W-1:0]       rows_left_q, rows_left_d;
  logic [ROW_W-1:0]       wr_left_q, wr_left_d;
  logic                   acc_q, acc_d;
  logic                   wr_strobe;

  valid_delay_line #(.DEPTH(PIPE_LAT)) u_valid_dl (
    .clk  (clk),
    .rstn (rstn),
    .clear(abort),
    .din  (ub_en_q),
    .dout (wr_strobe)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    fifo_d      = 1'b0;
    we_rl_d     = 1'b0;
    ub_en_d     = 1'b0;
    ub_addr_d   = ub_addr_q;
    wr_addr_d   = wr_addr_q;
    rows_left_d = rows_left_q;
    wr_left_d   = wr_left_q;
    acc_d       = acc_q;

    // Writes can overlap streaming when PIPE_LAT is shorter than the job.
    if (wr_strobe) begin
      wr_left_d = wr_left_q - ROW_W'(1);
      wr_addr_d = wr_addr_q + ADDRESSSIZE'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_rows != '0) begin
            state_d     = ST_POP_W;
            fifo_d      = 1'b1;
            rows_left_d = num_rows;
            wr_left_d   = num_rows;
            ub_addr_d   = ub_base;
            wr_addr_d   = res_base;
            acc_d       = acc_mode;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_POP_W: begin
        state_d = ST_RELOAD_W;
        we_rl_d = 1'b1;
      end
      ST_RELOAD_W: begin
        state_d = ST_STREAM;
        ub_en_d = 1'b1;
      end
      ST_STREAM: begin
        if (rows_left_q == ROW_W'(1)) begin
          state_d     = ST_DRAIN;
          rows_left_d = '0;
        end else begin
          ub_en_d     = 1'b1;
          ub_addr_d   = ub_addr_q + ADDRESSSIZE'(1);
          rows_left_d = rows_left_q - ROW_W'(1);
        end
      end
      ST_DRAIN: begin
        if (wr_strobe && wr_left_q == ROW_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        acc_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      done_d      = 1'b0;
      fifo_d      = 1'b0;
      we_rl_d     = 1'b0;
      ub_en_d     = 1'b0;
      ub_addr_d   = '0;
      wr_addr_d   = '0;
      rows_left_d = '0;
      wr_left_d   = '0;
      acc_d       = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fifo_q      <= 1'b0;
      we_rl_q     <= 1'b0;
      ub_en_q     <= 1'b0;
      ub_addr_q   <= '0;
      wr_addr_q   <= '0;
      rows_left_q <= '0;
      wr_left_q   <= '0;
      acc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fifo_q      <= fifo_d;
      we_rl_q     <= we_rl_d;
      ub_en_q     <= ub_en_d;
      ub_addr_q   <= ub_addr_d;
      wr_addr_q   <= wr_addr_d;
      rows_left_q <= rows_left_d;
      wr_left_q   <= wr_left_d;
      acc_q       <= acc_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign fifo_read_enable = fifo_q;
  assign we_rl            = we_rl_q;
  assign ub_read_en       = ub_en_q;
  assign ub_address       = ub_addr_q;
  assign res_write_enable = wr_strobe;
  assign res_address      = wr_addr_q;
  assign res_accumulate   = acc_q;

endmodule
